booth_ctrl: RTL and testbench

//  Sequencing FSM for the radix-2 Booth multiplier datapath. Drives the

---
 rtl/booth_ctrl.sv | 128 ++++++++++++
 tb/tb_booth_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_ctrl.sv
// Sequencing FSM for a radix-2 Booth multiplier datapath.
// Issues load/clear, add/sub and shift strobes for WIDTH iterations per start,
// then pulses done for one cycle. Holds no arithmetic.
// Optional feature: define BOOTH_CTRL_ABORT_EN to add an abort input that
// cancels a running sequence.
module booth_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       q_pair,
`ifdef BOOTH_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             load_m,
  output logic             load_q,
  output logic             clr_a,
  output logic             add_m,
  output logic             sub_m,
  output logic             shift,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StEval  = 3'd2,
    StShift = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_hit;

`ifdef BOOTH_CTRL_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // State and iteration counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter update; unused encodings fall back to idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start) state_d = StLoad;
      end
      StLoad: begin
        cnt_d   = CNT_W'(WIDTH);
        state_d = StEval;
      end
      StEval: begin
        state_d = StShift;
      end
      StShift: begin
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = (cnt_q == CNT_W'(1)) ? StDone : StEval;
      end
      StDone: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
    // Abort wins over every transition of an active sequence, including the last shift.
    if (abort_hit && (state_q == StLoad || state_q == StEval || state_q == StShift)) begin
      cnt_d   = '0;
      state_d = StIdle;
    end
  end

  // Output decode from the registered state; q_pair only matters in EVAL.
  always_comb begin
    load_m = 1'b0;
    load_q = 1'b0;
    clr_a  = 1'b0;
    add_m  = 1'b0;
    sub_m  = 1'b0;
    shift  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state_q)
      StLoad: begin
        load_m = 1'b1;
        load_q = 1'b1;
        clr_a  = 1'b1;
        busy   = 1'b1;
      end
      StEval: begin
        busy  = 1'b1;
        add_m = (q_pair == 2'b01);
        sub_m = (q_pair == 2'b10);
      end
      StShift: begin
        shift = 1'b1;
        busy  = 1'b1;
      end
      StDone: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign iter_cnt = cnt_q;

endmodule

// File: tb/tb_booth_ctrl.sv
// Directed bench for booth_ctrl (WIDTH=4) with a small Booth datapath model.
module tb_booth_ctrl;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  // Output vector order: {load_m, load_q, clr_a, add_m, sub_m, shift, busy, done}
  localparam logic [7:0] VIdle  = 8'b0000_0000;
  localparam logic [7:0] VLoad  = 8'b1110_0010;
  localparam logic [7:0] VEvalN = 8'b0000_0010;
  localparam logic [7:0] VShift = 8'b0000_0110;
  localparam logic [7:0] VDone  = 8'b0000_0001;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       q_pair;
  logic             abort = 1'b0;
  logic             load_m, load_q, clr_a, add_m, sub_m, shift, busy, done;
  logic [CNT_W-1:0] iter_cnt;

  int checks = 0;
  int failures = 0;

  // Datapath model: A, Q, Q[-1], M, driven by the controller strobes.
  logic       use_model = 1'b0;
  logic [1:0] q_pair_drv = 2'b00;
  logic [3:0] mcand = 4'd0;
  logic [3:0] mult = 4'd0;
  logic [3:0] a, q, m;
  logic       qm1;

  assign q_pair = use_model ? {q[0], qm1} : q_pair_drv;

  booth_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .q_pair   (q_pair),
`ifdef BOOTH_CTRL_ABORT_EN
    .abort    (abort),
`endif
    .load_m   (load_m),
    .load_q   (load_q),
    .clr_a    (clr_a),
    .add_m    (add_m),
    .sub_m    (sub_m),
    .shift    (shift),
    .busy     (busy),
    .done     (done),
    .iter_cnt (iter_cnt)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (load_m) m <= mcand;
    if (load_q) begin
      q   <= mult;
      qm1 <= 1'b0;
    end
    if (clr_a) a <= 4'd0;
    if (add_m) a <= a + m;
    if (sub_m) a <= a - m;
    if (shift) {a, q, qm1} <= {a[3], a, q};
  end

  function automatic logic [7:0] outs();
    return {load_m, load_q, clr_a, add_m, sub_m, shift, busy, done};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full run; ea/es give the expected add_m/sub_m per EVAL (bit i = iteration i).
  task automatic run_one(input string tag, input logic [3:0] ea, input logic [3:0] es);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_load"}, outs(), VLoad);
    chk({tag, "_load_cnt"}, 8'(iter_cnt), 8'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk({tag, "_eval"}, outs(), {3'b000, ea[i], es[i], 3'b010});
      chk({tag, "_eval_cnt"}, 8'(iter_cnt), 8'(4 - i));
      step();
      chk({tag, "_shift"}, outs(), VShift);
      chk({tag, "_shift_cnt"}, 8'(iter_cnt), 8'(4 - i));
    end
    step();
    chk({tag, "_done"}, outs(), VDone);
    chk({tag, "_done_cnt"}, 8'(iter_cnt), 8'd0);
    step();
    chk({tag, "_idle"}, outs(), VIdle);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dones;
    int done_at;
    logic [7:0] ev;
    int p;

    // Reset state
    #12;
    chk("reset_outs", outs(), VIdle);
    chk("reset_cnt", 8'(iter_cnt), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("idle_no_start", outs(), VIdle);

    // q_pair held 00: no add/sub, four shifts, done on 10th edge from start edge
    q_pair_drv = 2'b00;
    run_one("zeros", 4'b0000, 4'b0000);

    // Booth decode with datapath: multiplier 3, multiplicand -5 -> 8'hF1
    use_model = 1'b1;
    mult      = 4'b0011;
    mcand     = 4'b1011;
    run_one("booth", 4'b0100, 4'b0001);
    chk("product", {a, q}, 8'hF1);
    use_model = 1'b0;

    // Async reset mid-SHIFT clears outputs before the next edge
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("pre_rst_shift", outs(), VShift);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outs", outs(), VIdle);
    chk("async_rst_cnt", 8'(iter_cnt), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (done) dones++;
    end
    chk("rst_no_done", 8'(dones), 8'd0);

    // start held high: back-to-back runs with an 11-cycle period
    start = 1'b1;
    for (int n = 1; n <= 33; n++) begin
      step();
      p = (n - 1) % 11 + 1;
      if (p == 1) ev = VLoad;
      else if (p == 10) ev = VDone;
      else if (p == 11) ev = VIdle;
      else if (p % 2 == 0) ev = VEvalN;
      else ev = VShift;
      if (ev != outs()) chk($sformatf("b2b_n%0d", n), outs(), ev);
      else checks++;
    end
    start = 1'b0;
    step();
    chk("b2b_stop", outs(), VIdle);

    // start pulses while busy and in DONE are ignored
    dones   = 0;
    done_at = 0;
    start   = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (done) begin
        dones++;
        done_at = n;
      end
      if (n == 11) chk("start_in_done_ignored", outs(), VIdle);
      // toggle during the run, high at the edge sampled in DONE, low afterwards
      start = (n < 10) ? n[0] : (n == 10);
    end
    chk("one_done_per_start", 8'(dones), 8'd1);
    chk("done_latency", 8'(done_at), 8'd10);

`ifdef BOOTH_CTRL_ABORT_EN
    // Abort in the second EVAL
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("abort_eval2", outs(), VEvalN);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", outs(), VIdle);
    chk("abort_cnt", 8'(iter_cnt), 8'd0);
    dones = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (done) dones++;
    end
    chk("abort_no_done", 8'(dones), 8'd0);
    run_one("after_abort", 4'b0000, 4'b0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
